// File: rtl/sido_rail_monitor_pkg.sv
// Shared types and constants for the SIDO rail monitor (package sido_pkg).
// Build option: define SIDO_MON_AVG_EN to enable the 4-sample moving average.
package sido_pkg;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        REQUEST   = 2'd1,
        EMERGENCY = 2'd2,
        STALE     = 2'd3
    } rail_state_e;

    localparam int unsigned ADC_W = 12;
    localparam int unsigned ERR_W = 13;
    localparam int unsigned WD_W  = 10;
    localparam int unsigned CNT_W = 3;

    localparam logic RAIL_3V3 = 1'b0;
    localparam logic RAIL_5V  = 1'b1;

    localparam logic [ADC_W-1:0] REF_3V3 = 12'd2048;
    localparam logic [ADC_W-1:0] REF_5V  = 12'd3103;

    localparam logic signed [ERR_W-1:0] REQ_ON   = 13'sd20;
    localparam logic signed [ERR_W-1:0] REQ_OFF  = 13'sd5;
    localparam logic signed [ERR_W-1:0] EMERG_TH = 13'sd150;

    localparam logic [CNT_W-1:0] EMERG_CNT = 3'd3;
    localparam logic [WD_W-1:0]  TIMEOUT   = 10'd1023;

endpackage

// File: rtl/sido_rail_channel.sv
// One rail of the monitor: optional moving average, error vs REF, request FSM and watchdog.
// Build option: SIDO_MON_AVG_EN selects the averaged path; otherwise the raw sample is used.
module sido_rail_channel
    import sido_pkg::*;
#(
    parameter logic [ADC_W-1:0] REF = 12'd2048
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_valid,
    input  logic [ADC_W-1:0]        sample_data,
    output logic signed [ERR_W-1:0] error,
    output logic                    request,
    output logic                    emergency,
    output logic                    stale
);

    logic [ADC_W-1:0] filtered;

`ifdef SIDO_MON_AVG_EN
    logic [ADC_W-1:0] hist_q [4];
    logic [ADC_W-1:0] hist_d [4];
    logic [13:0]      sum_q, sum_d;

    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        if (sample_valid) begin
            sum_d     = sum_q - {2'b00, hist_q[3]} + {2'b00, sample_data};
            hist_d[0] = sample_data;
            for (int unsigned i = 1; i < 4; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // Filtered value uses the updated sum so the new sample counts this cycle.
    assign filtered = sum_d[13:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                hist_q[i] <= REF;
            end
            sum_q <= {REF, 2'b00};
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
        end
    end
`else
    assign filtered = sample_data;
`endif

    logic signed [ERR_W-1:0] err_new;
    assign err_new = signed'({1'b0, REF}) - signed'({1'b0, filtered});

    rail_state_e             state_q, state_d;
    logic [CNT_W-1:0]        emerg_cnt_q, emerg_cnt_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic signed [ERR_W-1:0] error_q, error_d;
    logic                    request_q, request_d;
    logic                    emergency_q, emergency_d;
    logic                    stale_q, stale_d;

    rail_state_e      base_state;
    logic [CNT_W-1:0] base_cnt;

    always_comb begin
        state_d     = state_q;
        emerg_cnt_d = emerg_cnt_q;
        wd_d        = wd_q;
        error_d     = error_q;
        base_state  = state_q;
        base_cnt    = emerg_cnt_q;

        if (sample_valid) begin
            error_d = err_new;
            wd_d    = '0;
            // A stale rail restarts from NORMAL with a fresh emergency run.
            if (state_q == STALE) begin
                base_state = NORMAL;
                base_cnt   = '0;
            end
            if (err_new >= EMERG_TH) begin
                emerg_cnt_d = (base_cnt == EMERG_CNT) ? EMERG_CNT : base_cnt + 1'b1;
            end else begin
                emerg_cnt_d = '0;
            end

            state_d = base_state;
            case (base_state)
                NORMAL:    if (err_new >= REQ_ON) state_d = REQUEST;
                REQUEST:   if (err_new <= REQ_OFF) state_d = NORMAL;
                EMERGENCY: begin
                    if (err_new <= REQ_OFF)       state_d = NORMAL;
                    else if (err_new < EMERG_TH)  state_d = REQUEST;
                end
                default:   state_d = NORMAL;
            endcase
            if (emerg_cnt_d == EMERG_CNT) begin
                state_d = EMERGENCY;
            end
        end else begin
            wd_d = (wd_q == TIMEOUT) ? wd_q : wd_q + 1'b1;
            if (wd_d == TIMEOUT) begin
                state_d = STALE;
            end
        end

        request_d   = (state_d == REQUEST) || (state_d == EMERGENCY);
        emergency_d = (state_d == EMERGENCY);
        stale_d     = (state_d == STALE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= NORMAL;
            emerg_cnt_q <= '0;
            wd_q        <= '0;
            error_q     <= '0;
            request_q   <= 1'b0;
            emergency_q <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            emerg_cnt_q <= emerg_cnt_d;
            wd_q        <= wd_d;
            error_q     <= error_d;
            request_q   <= request_d;
            emergency_q <= emergency_d;
            stale_q     <= stale_d;
        end
    end

    assign error     = error_q;
    assign request   = request_q;
    assign emergency = emergency_q;
    assign stale     = stale_q;

endmodule

// File: rtl/sido_rail_monitor.sv
// Top of the SIDO rail monitor: demuxes ADC samples to the 3.3 V and 5 V rail channels.
// Build option: SIDO_MON_AVG_EN enables per-rail 4-sample moving average.
module sido_rail_monitor
    import sido_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    adc_valid,
    input  logic                    adc_ch,
    input  logic [ADC_W-1:0]        adc_data,
    output logic signed [ERR_W-1:0] error_3v3,
    output logic signed [ERR_W-1:0] error_5v,
    output logic                    request_3V3,
    output logic                    request_5V,
    output logic                    emergency_3v3,
    output logic                    emergency_5v,
    output logic                    stale_3v3,
    output logic                    stale_5v
);

    logic valid_3v3;
    logic valid_5v;

    assign valid_3v3 = adc_valid && (adc_ch == RAIL_3V3);
    assign valid_5v  = adc_valid && (adc_ch == RAIL_5V);

    sido_rail_channel #(.REF(REF_3V3)) u_rail_3v3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (valid_3v3),
        .sample_data  (adc_data),
        .error        (error_3v3),
        .request      (request_3V3),
        .emergency    (emergency_3v3),
        .stale        (stale_3v3)
    );

    sido_rail_channel #(.REF(REF_5V)) u_rail_5v (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (valid_5v),
        .sample_data  (adc_data),
        .error        (error_5v),
        .request      (request_5V),
        .emergency    (emergency_5v),
        .stale        (stale_5v)
    );

endmodule

// File: tb/tb_sido_rail_monitor.sv
// Directed self-checking bench for sido_rail_monitor; expectations follow SIDO_MON_AVG_EN.
module tb_sido_rail_monitor;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               adc_valid = 1'b0;
    logic               adc_ch = 1'b0;
    logic [11:0]        adc_data = '0;
    logic signed [12:0] error_3v3, error_5v;
    logic               request_3V3, request_5V;
    logic               emergency_3v3, emergency_5v;
    logic               stale_3v3, stale_5v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sido_rail_monitor dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .adc_valid     (adc_valid),
        .adc_ch        (adc_ch),
        .adc_data      (adc_data),
        .error_3v3     (error_3v3),
        .error_5v      (error_5v),
        .request_3V3   (request_3V3),
        .request_5V    (request_5V),
        .emergency_3v3 (emergency_3v3),
        .emergency_5v  (emergency_5v),
        .stale_3v3     (stale_3v3),
        .stale_5v      (stale_5v)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic ch, input int data);
        @(negedge clk);
        adc_valid = 1'b1;
        adc_ch    = ch;
        adc_data  = data[11:0];
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_err3"},   error_3v3, 0);
        check({tag, "_err5"},   error_5v, 0);
        check({tag, "_req3"},   request_3V3, 0);
        check({tag, "_req5"},   request_5V, 0);
        check({tag, "_em3"},    emergency_3v3, 0);
        check({tag, "_em5"},    emergency_5v, 0);
        check({tag, "_stale3"}, stale_3v3, 0);
        check({tag, "_stale5"}, stale_5v, 0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

`ifdef SIDO_MON_AVG_EN
        send(1'b0, 1948);
        check("avg1_err", error_3v3, 25);
        check("avg1_req", request_3V3, 1);
        send(1'b0, 1948);
        check("avg2_err", error_3v3, 50);
        send(1'b0, 1948);
        check("avg3_err", error_3v3, 75);
        send(1'b0, 1948);
        check("avg4_err", error_3v3, 100);
        check("avg4_req", request_3V3, 1);
        send(1'b1, 3103);
        check("avg5v_err", error_5v, 0);

        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("avg_rst");
        @(negedge clk);
        reset_n = 1'b1;
        send(1'b0, 1948);
        check("avg_post_rst_err", error_3v3, 25);
`else
        send(1'b0, 2048);
        check("nom3_err", error_3v3, 0);
        check("nom3_req", request_3V3, 0);
        send(1'b1, 3103);
        check("nom5_err", error_5v, 0);

        send(1'b0, 2020);
        check("hys1_err", error_3v3, 28);
        check("hys1_req", request_3V3, 1);
        send(1'b0, 2040);
        check("hys2_err", error_3v3, 8);
        check("hys2_req", request_3V3, 1);
        send(1'b0, 2045);
        check("hys3_err", error_3v3, 3);
        check("hys3_req", request_3V3, 0);

        send(1'b1, 2900);
        check("em5_1_err", error_5v, 203);
        check("em5_1_req", request_5V, 1);
        check("em5_1_em", emergency_5v, 0);
        send(1'b1, 2900);
        check("em5_2_em", emergency_5v, 0);
        send(1'b1, 2900);
        check("em5_3_em", emergency_5v, 1);
        check("em5_3_req", request_5V, 1);
        send(1'b1, 3000);
        check("em5_4_err", error_5v, 103);
        check("em5_4_em", emergency_5v, 0);
        check("em5_4_req", request_5V, 1);

        send(1'b0, 1800);
        check("il1_err", error_3v3, 248);
        check("il1_em", emergency_3v3, 0);
        send(1'b1, 3103);
        check("il2_req5", request_5V, 0);
        send(1'b0, 1800);
        check("il3_em", emergency_3v3, 0);
        send(1'b0, 1800);
        check("il4_em3", emergency_3v3, 1);
        check("il4_req3", request_3V3, 1);
        check("il4_em5", emergency_5v, 0);

        send(1'b1, 3000);
        check("wd_req5", request_5V, 1);
        repeat (1022) @(posedge clk);
        #1;
        check("wd_pre_stale", stale_5v, 0);
        check("wd_pre_req", request_5V, 1);
        @(posedge clk);
        #1;
        check("wd_stale", stale_5v, 1);
        check("wd_stale_req", request_5V, 0);
        check("wd_stale_err", error_5v, 103);
        send(1'b1, 3103);
        check("wd_clr_stale", stale_5v, 0);
        check("wd_clr_err", error_5v, 0);

        send(1'b0, 1800);
        check("pre_rst_err", error_3v3, 248);
        check("pre_rst_req", request_3V3, 1);
        check("pre_rst_em", emergency_3v3, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sido_rail_monitor.md
# sido_rail_monitor

Front-end monitor that converts time-multiplexed ADC samples of the 3.3 V and 5 V rails into the per-rail error, request and emergency signals consumed by the SIDO switching controller. Each rail has an optional 4-sample moving average, a signed error against a fixed reference, a hysteretic request FSM, consecutive-sample emergency qualification and a stale-sample watchdog. It sits directly upstream of the controller, between the ADC sequencer and the controller's request/error/emergency inputs.

## Interface
- REF_3V3, 12'd2048, ADC code of nominal 3.3 V rail
- REF_5V, 12'd3103, ADC code of nominal 5 V rail
- REQ_ON, 13'sd20, error at or above which a request asserts
- REQ_OFF, 13'sd5, error at or below which request/emergency clear
- EMERG_TH, 13'sd150, emergency threshold
- EMERG_CNT, 3, consecutive samples ≥ EMERG_TH to declare emergency (1..7)
- TIMEOUT, 1023, cycles without a sample before a rail goes stale (10-bit counter)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- adc_valid  in  1  one-cycle strobe: adc_data/adc_ch valid
- adc_ch  in  1  0 = 3.3 V rail, 1 = 5 V rail
- adc_data  in  12  unsigned rail sample
- error_3v3, error_5v  out  13 signed  REF − filtered sample
- request_3V3, request_5V  out  1  rail needs energy
- emergency_3v3, emergency_5v  out  1  rail in qualified emergency
- stale_3v3, stale_5v  out  1  rail sample watchdog expired

## Operation
- Sample routed by adc_ch to its rail; other rail untouched.
- Average (see Configuration): running sum(14 b) = sum − oldest + new; filtered = sum >> 2. History resets to REF value, so error starts at 0.
- error = {1'b0,REF} − {1'b0,filtered}; range −4095..+4095, no saturation needed.
- Per-rail FSM evaluated only on an accepted sample, using the new error e:
  - NORMAL: e ≥ REQ_ON → REQUEST.
  - REQUEST: e ≤ REQ_OFF → NORMAL.
  - EMERGENCY: e ≤ REQ_OFF → NORMAL; REQ_OFF < e < EMERG_TH → REQUEST.
  - Any non-STALE state: emerg counter +1 (saturating at EMERG_CNT) if e ≥ EMERG_TH, else cleared; counter reaching EMERG_CNT → EMERGENCY (takes precedence).
  - STALE: on sample, counter cleared, then evaluated exactly as NORMAL.
- Watchdog: per-rail counter cleared on own sample, else increments, saturating; reaching TIMEOUT → STALE from any state.
- Outputs registered: request = REQUEST|EMERGENCY; emergency = EMERGENCY; stale = STALE. In STALE request/emergency forced 0, error holds last value.

## Timing
- Reset: all outputs 0, errors 0, FSMs NORMAL, counters 0, history = REF.
- Latency: adc_valid at edge N → error/request/emergency updated at edge N+1 (one register stage).
- adc_valid back-to-back every cycle supported; no backpressure.
- Sample and watchdog expiry in same cycle: sample wins, no STALE.
- Emergency needs EMERG_CNT same-rail samples with e ≥ EMERG_TH; other-rail samples in between do not break the run.
- reset_n asserted mid-operation: immediate return to reset values regardless of clk.

## Configuration
- SIDO_MON_AVG_EN defined: 4-sample moving average per rail as above.
- Not defined: history/sum logic removed; filtered = adc_data directly; latency and all other behaviour identical.

## Structure
- Shared package sido_pkg: rail FSM state enum (NORMAL, REQUEST, EMERGENCY, STALE), error width constant (13), rail index constants.
- One sub-module sido_rail_channel (filter, error, FSM, watchdog, parameterised by REF), instantiated twice; top level only demuxes adc_valid by adc_ch.

## Test plan
- Reset, then 3V3 sample 2048 → error_3v3 = 0, no request; 5V sample 3103 → error_5v = 0.
- Avg off: 3V3 samples 2020, 2040, 2045 → request_3V3 rises after first (e = 28), holds at e = 8, falls at e = 3.
- Avg off: 5V samples 2900 ×3 (e = 203) → request_5V after first, emergency_5v one cycle after third; sample 3000 (e = 103) → emergency clears, request stays.
- Interleave 3V3 1800, 5V 3103, 3V3 1800, 3V3 1800 → emergency_3v3 after third 3V3 sample; 5V unaffected.
- No 5V sample for 1023 cycles while requesting → stale_5v = 1, request_5V = 0; next sample 3103 clears stale, error 0.
- Avg on: from reset, 3V3 samples 1948 ×4 → errors 25, 50, 75, 100; request_3V3 from first sample; reset_n pulse mid-sequence → all outputs 0.
